// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and default width for the GCD engine
package gcd_pkg;

    localparam int GCD_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_stein_step.sv
// rtl/gcd_stein_step.sv - one combinational binary-GCD (Stein) reduction step
module gcd_stein_step #(
    parameter int WIDTH = 16,
    localparam int KW   = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [KW-1:0]    k_nxt,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    // Select the single reduction that applies to the current operand pair
    always_comb begin
        a_nxt  = a;
        b_nxt  = b;
        k_nxt  = k;
        done   = 1'b0;
        // The surviving operand times the common power of two is the gcd;
        // it always fits in WIDTH because the true gcd does.
        result = (a | b) << k;
        if ((a == '0) || (b == '0)) begin
            done = 1'b1;
        end else if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            k_nxt = k + KW'(1);
        end else if (!a[0]) begin
            a_nxt = a >> 1;
        end else if (!b[0]) begin
            b_nxt = b >> 1;
        end else if (a >= b) begin
            // Difference of two odd numbers is even, so the halving is exact
            a_nxt = (a - b) >> 1;
        end else begin
            b_nxt = (b - a) >> 1;
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - handshaked iterative binary-GCD engine
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [2*WIDTH-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    localparam int KW = $clog2(WIDTH) + 1;

    gcd_state_t       state_q;
    gcd_state_t       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic [KW-1:0]    k_nxt;
    logic [WIDTH-1:0] step_result;
    logic             step_done;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    gcd_stein_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a      (a_q),
        .b      (b_q),
        .k      (k_q),
        .a_nxt  (a_nxt),
        .b_nxt  (b_nxt),
        .k_nxt  (k_nxt),
        .result (step_result),
        .done   (step_done)
    );

    // State register; reset drops straight back to IDLE without waiting for clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, iterate in CALC, hold result in DONE until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_xfer)   state_d = CALC;
            CALC:    if (step_done) state_d = DONE;
            DONE:    if (out_xfer)  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand, shift-count and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            out_data <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (in_xfer) begin
                    a_q <= in_data[2*WIDTH-1:WIDTH];
                    b_q <= in_data[WIDTH-1:0];
                    k_q <= '0;
                end
            end else if (state_q == CALC) begin
                if (step_done) begin
                    out_data <= step_result;
                end else begin
                    a_q <= a_nxt;
                    b_q <= b_nxt;
                    k_q <= k_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - randomized self-checking bench for gcd_engine
module tb_gcd_engine;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    logic        w_in_valid;
    logic [63:0] w_in_data;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_data;

    int n_tests = 0;
    int n_fail  = 0;

    gcd_engine #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    gcd_engine #(.WIDTH(32)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_data   (w_in_data),
        .in_ready  (w_in_ready),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_data  (w_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_gcd(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic send16(input logic [31:0] data);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("in_ready_before_send", in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_out16(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run16(input string tag, input logic [31:0] data, input logic [15:0] exp);
        int lat;
        out_ready = 1'b1;
        send16(data);
        wait_out16(lat);
        check_eq({tag, "_latency_ok"}, (lat <= 2*16 + 2), 1);
        check_eq({tag, "_data"}, out_data, exp);
        @(negedge clk);
        check_eq({tag, "_one_cycle"}, out_valid, 0);
        check_eq({tag, "_idle_again"}, in_ready, 1);
    endtask

    task automatic run32(input string tag, input logic [63:0] data, input logic [31:0] exp);
        int lat;
        w_out_ready = 1'b1;
        check_eq({tag, "_in_ready"}, w_in_ready, 1);
        w_in_valid = 1'b1;
        w_in_data  = data;
        @(negedge clk);
        w_in_valid = 1'b0;
        w_in_data  = {$urandom, $urandom};
        lat = 1;
        while (!w_out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency_ok"}, (lat <= 2*32 + 2), 1);
        check_eq({tag, "_data"}, w_out_data, exp);
        @(negedge clk);
        check_eq({tag, "_one_cycle"}, w_out_valid, 0);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] x;
        logic [15:0] y;
        logic        bad;
        int          n_in;
        int          n_out;
        int          guard;
        int          sh;

        rst         = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        w_in_valid  = 1'b0;
        w_in_data   = '0;
        w_out_ready = 1'b0;

        @(negedge clk);
        check_eq("reset_in_ready", in_ready, 1);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_out_data", out_data, 0);
        check_eq("reset_w_in_ready", w_in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run16("gcd_30_20", 32'h0030_0020, 16'h0010);
        run16("gcd_11_0d", 32'h0011_000D, 16'h0001);
        run16("gcd_0_7",   32'h0000_0007, 16'h0007);
        run16("gcd_0_0",   32'h0000_0000, 16'h0000);
        run16("gcd_ff_ff", 32'hFFFF_FFFF, 16'hFFFF);
        run16("gcd_7_0",   32'h0007_0000, 16'h0007);

        // Backpressure: result must hold while the consumer stalls
        out_ready = 1'b0;
        send16(32'h0030_0020);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("bp_valid_seen", out_valid, 1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            if (out_data !== 16'h0010 || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("bp_hold_stable", bad, 0);
        check_eq("bp_hold_data", out_data, 16'h0010);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_idle", in_ready, 1);
        check_eq("bp_release_valid", out_valid, 0);

        // Reset in the middle of a calculation
        send16(32'h0030_0020);
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_mid_calc_busy", in_ready, 0);
        rst = 1'b0;
        #1;
        check_eq("rst_async_in_ready", in_ready, 1);
        check_eq("rst_async_out_valid", out_valid, 0);
        check_eq("rst_async_out_data", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        check_eq("rst_no_stale_result", bad, 0);
        run16("gcd_12_08", 32'h0012_0008, 16'h0002);

        // Wide instance boundary cases
        run32("w_8000_0", {32'h8000_0000, 32'h0000_0000}, 32'h8000_0000);
        run32("w_c000_4000", {32'hC000_0000, 32'h4000_0000}, 32'h4000_0000);

        // Randomized back-to-back traffic with random backpressure
        n_in  = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: begin x = x & 16'h00FF; y = y & 16'h00FF; end
                2: begin
                    sh = $urandom_range(1, 8);
                    x = (x & 16'h00FF) << sh;
                    y = (y & 16'h00FF) << sh;
                end
                default: if ($urandom_range(0, 1) == 0) x = '0; else y = '0;
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {x, y};
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(16'(ref_gcd({48'h0, x}, {48'h0, y})));
                n_in++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check_eq("rand_unexpected_result", 1, 0);
                end else begin
                    check_eq("rand_result", out_data, exp_q.pop_front());
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            if (out_valid) begin
                n_out++;
                check_eq("drain_result", out_data, exp_q.pop_front());
            end
            @(negedge clk);
            guard++;
        end
        check_eq("rand_queue_empty", exp_q.size(), 0);
        check_eq("rand_in_out_count", n_out, n_in);
        check_eq("rand_some_traffic", (n_in > 100), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits (legal 4..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 SHALL have port in_data, input, 2*WIDTH, packed operands: a = in_data[2*WIDTH-1:WIDTH], b = in_data[WIDTH-1:0].
REQ-006 SHALL have port in_ready, output, 1, engine accepts an operand pair.
REQ-007 SHALL have port out_valid, output, 1, result available.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts the result (new; backpressure).
REQ-009 SHALL have port out_data, output, WIDTH, gcd(a,b).

Function
REQ-010 SHALL implement states IDLE, CALC, DONE; input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-011 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-012 IDLE: on input transfer, SHALL register a, b, clear shift count k (clog2(WIDTH)+1 bits), and enter CALC next cycle.
REQ-013 CALC: SHALL perform exactly one binary-GCD (Stein) step per cycle:
  - a==0 or b==0: out_data <= (a|b) << k, go to DONE;
  - both even: a>>=1, b>>=1, k+=1;
  - only a even: a>>=1;
  - only b even: b>>=1;
  - both odd, a>=b: a <= (a-b)>>1;
  - both odd, a<b: b <= (b-a)>>1.
REQ-014 All datapath arithmetic SHALL be WIDTH bits unsigned; subtraction never underflows given REQ-013 ordering; the final shift SHALL not overflow, since the true gcd fits in WIDTH.
REQ-015 CALC SHALL last at most 2*WIDTH+1 cycles for any operands; input-transfer-to-out_valid latency is 1 + CALC cycles.
REQ-016 DONE: out_data and out_valid SHALL hold stable until the output transfer, then return to IDLE on the next cycle; in_ready SHALL stay low throughout DONE.
REQ-017 gcd(0,0) SHALL yield 0; gcd(0,b) SHALL yield b; gcd(a,a) SHALL yield a.
REQ-018 in_data SHALL be ignored outside the input transfer cycle; out_ready SHALL be ignored outside DONE.

Reset
REQ-019 rst low SHALL immediately force state IDLE, clear a, b, k and out_data to 0, and set out_valid=0, in_ready=1, independent of clk.
REQ-020 Reset asserted mid-CALC or mid-DONE SHALL abandon the operation with no result emitted; the first input transfer after release SHALL compute normally.
REQ-021 Reset release SHALL be synchronised externally; the block SHALL require no specific relation between rst deassertion and clk.

Structure
REQ-022 State encoding (IDLE/CALC/DONE typedef) and the default WIDTH constant SHALL live in shared package gcd_pkg.
REQ-023 The per-cycle combinational step (REQ-013 case selection) SHALL be sub-module gcd_stein_step, parametrised by WIDTH, with inputs a, b, k and outputs next a, b, k and a done flag.
REQ-024 gcd_engine SHALL contain only the state register, operand/count/result registers and handshake logic.

Verification
REQ-025 WIDTH=16, in_data=0x0030_0020, out_ready=1 -> out_data=0x0010, out_valid within 2*16+2 cycles of the input transfer, for one cycle only.
REQ-026 in_data=0x0011_000D, 0x0000_0007, 0x0000_0000, 0xFFFF_FFFF -> 0x0001, 0x0007, 0x0000, 0xFFFF respectively.
REQ-027 Backpressure: out_ready=0 for 10 cycles after out_valid on 0x0030_0020 -> out_data holds 0x0010, in_ready stays 0; out_ready=1 -> IDLE next cycle.
REQ-028 rst pulled low 3 cycles after accepting 0x0030_0020 -> outputs at reset values immediately, no out_valid; then 0x0012_0008 -> 0x0002.
REQ-029 WIDTH=32, in_data={32'h8000_0000, 32'h0000_0000} and {32'hC000_0000, 32'h4000_0000} -> 0x8000_0000 and 0x4000_0000, each within 65 CALC cycles.
REQ-030 Randomised back-to-back pairs vs. reference-model gcd with random out_ready -> every result matches, none dropped or duplicated.
